// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file port logic.
package regfile_pkg;

    // INIT zero-fills the file, ARB shares its port between requesters.
    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } arb_state_t;

    localparam int REGFILE_ADDR_W = 6;
    localparam int REGFILE_DATA_W = 16;

endpackage

// File: rtl/regfile_port_arbiter_rr.sv
// Generic round-robin arbiter: combinational one-hot grant, registered
// pointer to the last winner so the scan restarts just past it.
module rr_arbiter #(
    parameter int NumRequesters = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             en_i,
    input  logic [NumRequesters-1:0]         req_i,
    output logic [NumRequesters-1:0]         gnt_o,
    output logic                             gnt_valid_o,
    output logic [$clog2(NumRequesters)-1:0] gnt_idx_o
);

    localparam int IdxW = $clog2(NumRequesters);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand;
    logic            found;

    // Scan from ptr+1 around the ring; first asserted request wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NumRequesters; k++) begin
            cand = IdxW'((int'(ptr_q) + k) % NumRequesters);
            if (en_i && !found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
        gnt_valid_o = found;
        ptr_d       = found ? gnt_idx_o : ptr_q;
    end

    // Pointer starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= IdxW'(NumRequesters - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file's write/read-A port between requesters.
//
//   state | meaning
//   INIT  | zero-filling registers 0..RegisterHeight-1, no grants
//   ARB   | round-robin access, InitDone high
//
// The file port is driven combinationally from the state and the winning
// request, so the access lands in the grant cycle. While nReset is low the
// port is forced idle: INIT would otherwise already be writing address 0.
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int NumRequesters  = 4,
    parameter int AddressWidth   = REGFILE_ADDR_W,
    parameter int RegisterHeight = 1 << AddressWidth,
    parameter int RegisterWidth  = REGFILE_DATA_W,
    parameter bit InitOnReset    = 1'b1
) (
    input  logic                                   Clock,
    input  logic                                   nReset,
    input  logic [NumRequesters-1:0]               ReqValid,
    input  logic [NumRequesters-1:0]               ReqWrite,
    input  logic [NumRequesters*AddressWidth-1:0]  ReqAddr,
    input  logic [NumRequesters*RegisterWidth-1:0] ReqWData,
    output logic [NumRequesters-1:0]               ReqGrant,
    output logic [NumRequesters-1:0]               RspValid,
    output logic [RegisterWidth-1:0]               RspData,
    output logic                                   InitDone,
    output logic                                   RfWriteEnable,
    output logic [RegisterWidth-1:0]               RfWriteData,
    output logic [AddressWidth-1:0]                RfAddress,
    input  logic [RegisterWidth-1:0]               RfReadData
);

    localparam int IdxW = $clog2(NumRequesters);
    localparam logic [AddressWidth-1:0] LastAddr   = AddressWidth'(RegisterHeight - 1);
    localparam arb_state_t              ResetState = InitOnReset ? INIT : ARB;

    arb_state_t                 state_q, state_d;
    logic [AddressWidth-1:0]    init_cnt_q, init_cnt_d;
    logic [AddressWidth-1:0]    addr_q, addr_d;
    logic [RegisterWidth-1:0]   wdata_q, wdata_d;
    logic [NumRequesters-1:0]   rsp_valid_q, rsp_valid_d;
    logic [RegisterWidth-1:0]   rsp_data_q, rsp_data_d;

    logic                       init_active;
    logic                       arb_active;
    logic [NumRequesters-1:0]   gnt;
    logic                       gnt_valid;
    logic [IdxW-1:0]            gnt_idx;
    logic                       gnt_write;
    logic [AddressWidth-1:0]    gnt_addr;
    logic [RegisterWidth-1:0]   gnt_wdata;

    assign init_active = nReset && (state_q == INIT);
    assign arb_active  = nReset && (state_q == ARB);

    rr_arbiter #(
        .NumRequesters (NumRequesters)
    ) u_rr (
        .clk_i       (Clock),
        .rst_ni      (nReset),
        .en_i        (arb_active),
        .req_i       (ReqValid),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign gnt_write = ReqWrite[gnt_idx];
    assign gnt_addr  = ReqAddr[int'(gnt_idx) * AddressWidth +: AddressWidth];
    assign gnt_wdata = ReqWData[int'(gnt_idx) * RegisterWidth +: RegisterWidth];

    assign ReqGrant = gnt;
    assign InitDone = arb_active;
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;

    // File port: zero-fill in INIT, winning request in ARB, else hold.
    always_comb begin
        RfWriteEnable = 1'b0;
        RfAddress     = addr_q;
        RfWriteData   = wdata_q;
        if (init_active) begin
            RfWriteEnable = 1'b1;
            RfAddress     = init_cnt_q;
            RfWriteData   = '0;
        end else if (gnt_valid) begin
            RfWriteEnable = gnt_write;
            RfAddress     = gnt_addr;
            RfWriteData   = gnt_wdata;
        end
    end

    // Next state: fill counter stops at the last register, reads respond next cycle.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        addr_d      = RfAddress;
        wdata_d     = RfWriteData;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (state_q == INIT) begin
            if (init_cnt_q == LastAddr) begin
                state_d = ARB;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end
        if (gnt_valid && !gnt_write) begin
            rsp_valid_d = gnt;
            rsp_data_d  = RfReadData;
        end
    end

    // State, held port values and the read response register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ResetState;
            init_cnt_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule
